// File: rtl/muldiv_defs.sv
// Shared constants for the multiply/divide sequencer: FSM state codes, op codes
// and the fixed divide-by-zero quotient.
package muldiv_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [7:0] DBZ_QUOT  = 8'hFF;
    localparam int         ITER_LAST = 7;

endpackage

// File: rtl/AddSub_8bit.sv
// Core 8-bit add/subtract unit. cin=0 adds; cin=1 subtracts (a - b) and then
// reports cout as a borrow, so cout=0 means a >= b.
module AddSub_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ovf
);

    logic [7:0] b_eff;
    logic [8:0] full;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        b_eff = cin ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {8'b0, cin};
        sum   = full[7:0];
        cout  = full[8] ^ cin;
        ovf   = (a[7] == b_eff[7]) && (sum[7] != a[7]);
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned 8x8 multiply / 8/8 restoring divide, sharing one
// AddSub_8bit across 8 iterations. busy/done/dbz and results are all flops.
module muldiv_seq
    import muldiv_defs::*;
#(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             dbz
);

    logic [1:0]        state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [WIDTH-1:0]  hi_q, hi_d;    // acc (MUL) / rem (DIV)
    logic [WIDTH-1:0]  lo_q, lo_d;    // mq (MUL) / q (DIV)
    logic [WIDTH-1:0]  opd_q, opd_d;  // md (MUL) / d (DIV)
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic [WIDTH-1:0]  as_a, as_sum, rem_s;
    logic              as_cin, as_cout, ovf_unused;

    // DIV presents the left-shifted remainder; MUL presents the accumulator.
    always_comb begin
        rem_s  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        as_a   = (op_q == OP_DIV) ? rem_s : hi_q;
        as_cin = (op_q == OP_DIV);
    end

    AddSub_8bit u_addsub (
        .a    (as_a),
        .b    (opd_q),
        .cin  (as_cin),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (ovf_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opd_d   = opd_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op;
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    if (op == OP_DIV && b == '0) begin
                        state_d = ST_FIN;
                        hi_d    = a;
                        lo_d    = DBZ_QUOT;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        hi_d    = '0;
                        lo_d    = (op == OP_DIV) ? a : b;
                        opd_d   = (op == OP_DIV) ? b : a;
                    end
                end
            end
            ST_CALC: begin
                if (op_q == OP_MUL) begin
                    if (lo_q[0]) begin
                        hi_d = {as_cout, as_sum[WIDTH-1:1]};
                        lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[WIDTH-1:1]};
                        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                    end
                end else begin
                    // A set ninth bit means the shifted remainder already exceeds d.
                    if (hi_q[WIDTH-1] || !as_cout) begin
                        hi_d = as_sum;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = rem_s;
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
                if (cnt_q == ITER_W'(ITER_LAST)) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_FIN);
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opd_q   <= opd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign res_hi = hi_q;
    assign res_lo = lo_q;
    assign dbz    = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random MUL/DIV
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, dbz;
    logic [7:0] res_hi, res_lo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    muldiv_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .dbz    (dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {hi, lo}: MUL -> product; DIV -> {remainder, quotient}; DIV by 0 -> {a, FF}.
    function automatic logic [15:0] ref_res(input logic o, input logic [7:0] x, input logic [7:0] y);
        int unsigned p;
        if (o == 1'b0) begin
            p = int'(x) * int'(y);
            return p[15:0];
        end
        if (y == 8'd0) return {x, 8'hFF};
        return {8'(x % y), 8'(x / y)};
    endfunction

    // Called at a negedge. Pulses start for one edge, waits for done, checks
    // busy each cycle, latency, result, dbz, and that done is a single pulse.
    // repulse_k: cycle index at which a DIV 9/3 start is re-pulsed (0 = none);
    // repulse_done: also re-pulse during the done cycle.
    task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                          input int repulse_k, input bit repulse_done);
        logic [15:0] exp_res;
        bit          exp_dbz;
        int          exp_lat;
        bit          seen;
        exp_res = ref_res(o, x, y);
        exp_dbz = (o == 1'b1) && (y == 8'd0);
        exp_lat = exp_dbz ? 1 : 9;
        seen    = 1'b0;
        start = 1'b1; op = o; a = x; b = y;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (k == 1 && !exp_dbz) check("dbz_clear_on_accept", dbz, 0);
            if (done) begin
                seen = 1'b1;
                last_done_cyc = cyc;
                check("latency", k, exp_lat);
                check("busy_at_done", busy, 0);
                check("result", {res_hi, res_lo}, exp_res);
                check("dbz", dbz, exp_dbz);
                if (repulse_done) begin
                    start = 1'b1; op = 1'b1; a = 8'd9; b = 8'd3;
                end
            end else begin
                check("busy", busy, 1);
                if (k == repulse_k) begin
                    start = 1'b1; op = 1'b1; a = 8'd9; b = 8'd3;
                end
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("busy_after_done", busy, 0);
        check("result_held", {res_hi, res_lo}, exp_res);
        check("dbz_held", dbz, exp_dbz);
    endtask

    // Watches n cycles and counts unexpected done/busy activity.
    task automatic expect_quiet(input string tag, input int n);
        int extra;
        extra = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check(tag, extra, 0);
    endtask

    initial begin
        int d1;
        logic       ro;
        logic [7:0] ra, rb;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_res", {res_hi, res_lo}, 16'h0000);
        check("reset_dbz", dbz, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 8'hFF, 8'hFF, 0, 1'b0);
        run_op(1'b1, 8'd200, 8'd7, 0, 1'b0);
        run_op(1'b1, 8'hFF, 8'h01, 0, 1'b0);
        run_op(1'b1, 8'h5A, 8'h00, 0, 1'b0);
        run_op(1'b0, 8'h03, 8'h04, 0, 1'b0);

        // Re-pulsed starts while busy and during done are ignored.
        run_op(1'b0, 8'h12, 8'h34, 2, 1'b1);
        expect_quiet("no_second_done", 15);
        check("result_after_ignored", {res_hi, res_lo}, 16'h03A8);

        // Reset in the middle of an operation discards it.
        start = 1'b1; op = 1'b0; a = 8'h12; b = 8'h34;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_res", {res_hi, res_lo}, 16'h0000);
        check("midreset_dbz", dbz, 0);
        expect_quiet("midreset_quiet", 12);
        run_op(1'b0, 8'h80, 8'h02, 0, 1'b0);

        // Back-to-back: next start in the cycle right after done.
        run_op(1'b0, 8'h0B, 8'h0D, 0, 1'b0);
        d1 = last_done_cyc;
        run_op(1'b1, 8'd250, 8'd17, 0, 1'b0);
        check("b2b_spacing_ge10", (last_done_cyc - d1) >= 10, 1);

        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (ro == 1'b1 && $urandom_range(0, 7) == 0) rb = 8'd0;
            run_op(ro, ra, rb, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
